// File: rtl/x86_prefetch_decoder.sv
// ----------------------------------------------------------------------------
// x86_prefetch_decoder
//
// Byte prefetch queue plus prefix stripper for a 16-bit x86 core. Bytes are
// fetched from CS:IP into a circular queue. The decoder pops prefix bytes,
// merges them into one opcode record and hands the record to the execute
// stage over a valid/ready handshake. While a record is held, the execute
// stage may pop trailing bytes (modrm/imm/disp) through the byte port.
//
// Ports
//   clock_i, reset_i      clock, synchronous active-high reset
//   ce_i                  clock enable, 0 freezes all state
//   address_o, rd_o       bus fetch address {fcs,4'h0}+fip and read request
//   rdy_i, in_i           bus data valid and data for the outstanding read
//   flush_i, new_cs_i,    restart fetch and decode from new_cs:new_ip
//   new_ip_i
//   op_valid_o,           opcode record handshake
//   op_ready_i
//   opcode_o, op_ips_o,   record: opcode, start IP, segment, override flag,
//   op_seg_o, op_over_o,  rep kind, lock, 0F escape, prefix overflow fault
//   op_rep_o, op_lock_o,
//   op_ext_o, op_fault_o
//   byte_valid_o,         queue head visible while a record is held;
//   byte_data_o,          byte_take_i pops it
//   byte_take_i
// ----------------------------------------------------------------------------
module x86_prefetch_decoder #(
  parameter int          QDEPTH     = 6,
  parameter int          MAX_PREFIX = 14,
  parameter logic [15:0] RESET_CS   = 16'hF000,
  parameter logic [15:0] RESET_IP   = 16'hFFF0
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        ce_i,
  output logic [19:0] address_o,
  output logic        rd_o,
  input  logic        rdy_i,
  input  logic [7:0]  in_i,
  input  logic        flush_i,
  input  logic [15:0] new_cs_i,
  input  logic [15:0] new_ip_i,
  output logic        op_valid_o,
  input  logic        op_ready_i,
  output logic [7:0]  opcode_o,
  output logic [15:0] op_ips_o,
  output logic [1:0]  op_seg_o,
  output logic        op_over_o,
  output logic [1:0]  op_rep_o,
  output logic        op_lock_o,
  output logic        op_ext_o,
  output logic        op_fault_o,
  output logic        byte_valid_o,
  output logic [7:0]  byte_data_o,
  input  logic        byte_take_i
);

  localparam int PW = (QDEPTH > 2) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int FW = $clog2(MAX_PREFIX + 2);

  typedef enum logic {S_DEC, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [15:0]     fcs_q, fcs_d;
  logic [15:0]     fip_q, fip_d;
  logic [15:0]     dip_q, dip_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pending_q, pending_d;
  logic            stale_q, stale_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [15:0]     ips_q, ips_d;
  logic [1:0]      seg_q, seg_d;
  logic            over_q, over_d;
  logic [1:0]      rep_q, rep_d;
  logic            lock_q, lock_d;
  logic            ext_q, ext_d;
  logic            fault_q, fault_d;
  logic [FW-1:0]   pfx_cnt_q, pfx_cnt_d;
  logic [7:0]      mem_q [QDEPTH];

  logic [7:0] head;
  logic       q_empty, q_full, push, pop;
  logic       is_seg, is_rep, is_pfx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head    = mem_q[rd_ptr_q];
  assign q_empty = (count_q == '0);
  assign q_full  = (count_q == CW'(QDEPTH));

  // A stale read (dropped by flush) still occupies the bus until its rdy
  // arrives, so no new read may be issued before then.
  assign rd_o      = !pending_q && !stale_q && !q_full && !flush_i;
  assign address_o = {fcs_q, 4'h0} + {4'h0, fip_q};

  assign push = pending_q && rdy_i && !q_full;
  assign pop  = !q_empty && ((state_q == S_DEC) || (state_q == S_HOLD && byte_take_i));

  assign is_seg = head inside {8'h26, 8'h2E, 8'h36, 8'h3E};
  assign is_rep = head inside {8'hF2, 8'hF3};
  assign is_pfx = is_seg || is_rep || head inside {8'hF0, 8'h0F, [8'h64:8'h67]};

  assign op_valid_o   = (state_q == S_HOLD);
  assign byte_valid_o = (state_q == S_HOLD) && !q_empty;
  assign byte_data_o  = head;
  assign opcode_o     = opcode_q;
  assign op_ips_o     = ips_q;
  assign op_seg_o     = seg_q;
  assign op_over_o    = over_q;
  assign op_rep_o     = rep_q;
  assign op_lock_o    = lock_q;
  assign op_ext_o     = ext_q;
  assign op_fault_o   = fault_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a next-state value unassigned and no latch is inferred.
    state_d   = state_q;
    fcs_d     = fcs_q;
    fip_d     = fip_q;
    dip_d     = dip_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pending_d = pending_q;
    stale_d   = stale_q;
    opcode_d  = opcode_q;
    ips_d     = ips_q;
    seg_d     = seg_q;
    over_d    = over_q;
    rep_d     = rep_q;
    lock_d    = lock_q;
    ext_d     = ext_q;
    fault_d   = fault_q;
    pfx_cnt_d = pfx_cnt_q;

    if (rd_o) pending_d = 1'b1;
    if (pending_q && rdy_i) pending_d = 1'b0;
    if (stale_q && rdy_i) stale_d = 1'b0;

    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
      fip_d    = fip_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      dip_d    = dip_q + 16'd1;
    end
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    unique case (state_q)
      S_DEC: begin
        if (!q_empty) begin
          if (pfx_cnt_q == '0) ips_d = dip_q;
          if (is_pfx && pfx_cnt_q != FW'(MAX_PREFIX)) begin
            pfx_cnt_d = pfx_cnt_q + 1'b1;
            if (is_seg) begin
              seg_d  = head[4:3];
              over_d = 1'b1;
            end
            if (is_rep) rep_d = {1'b1, head[0]};
            if (head == 8'hF0) lock_d = 1'b1;
            if (head == 8'h0F) ext_d = 1'b1;
          end else begin
            // Either a real opcode, or one prefix too many: the overflowing
            // prefix byte becomes the opcode and the record is faulted.
            opcode_d = head;
            fault_d  = is_pfx;
            state_d  = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (op_ready_i) begin
          state_d   = S_DEC;
          seg_d     = 2'd3;
          over_d    = 1'b0;
          rep_d     = 2'd0;
          lock_d    = 1'b0;
          ext_d     = 1'b0;
          fault_d   = 1'b0;
          pfx_cnt_d = '0;
        end
      end
      default: state_d = S_DEC;
    endcase

    if (flush_i) begin
      state_d   = S_DEC;
      fcs_d     = new_cs_i;
      fip_d     = new_ip_i;
      dip_d     = new_ip_i;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      pending_d = 1'b0;
      // A read in flight keeps the bus busy; remember to discard its data.
      stale_d   = (pending_q || stale_q) && !rdy_i;
      seg_d     = 2'd3;
      over_d    = 1'b0;
      rep_d     = 2'd0;
      lock_d    = 1'b0;
      ext_d     = 1'b0;
      fault_d   = 1'b0;
      pfx_cnt_d = '0;
    end
  end

  always_ff @(posedge clock_i) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset_i) begin
      state_q   <= S_DEC;
      fcs_q     <= RESET_CS;
      fip_q     <= RESET_IP;
      dip_q     <= RESET_IP;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      stale_q   <= 1'b0;
      opcode_q  <= 8'h00;
      ips_q     <= 16'h0000;
      seg_q     <= 2'd3;
      over_q    <= 1'b0;
      rep_q     <= 2'd0;
      lock_q    <= 1'b0;
      ext_q     <= 1'b0;
      fault_q   <= 1'b0;
      pfx_cnt_q <= '0;
    end else if (ce_i) begin
      state_q   <= state_d;
      fcs_q     <= fcs_d;
      fip_q     <= fip_d;
      dip_q     <= dip_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      stale_q   <= stale_d;
      opcode_q  <= opcode_d;
      ips_q     <= ips_d;
      seg_q     <= seg_d;
      over_q    <= over_d;
      rep_q     <= rep_d;
      lock_q    <= lock_d;
      ext_q     <= ext_d;
      fault_q   <= fault_d;
      pfx_cnt_q <= pfx_cnt_d;
    end
  end

  // NOTE: the queue storage has no reset; count and pointers alone decide
  // which entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clock_i) begin
    if (ce_i && push && !flush_i) mem_q[wr_ptr_q] <= in_i;
  end

endmodule

// File: tb/tb_x86_prefetch_decoder.sv
// ----------------------------------------------------------------------------
// tb_x86_prefetch_decoder
//
// Bench for x86_prefetch_decoder. A bus model serves bytes from a sparse
// memory image; each scenario writes a short program, pushes the records it
// expects into a scoreboard, and a monitor pops and compares every accepted
// record. Scenario tasks also compare handshake/bus signals inline.
// ----------------------------------------------------------------------------
module tb_x86_prefetch_decoder;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        ce_i;
  logic [19:0] address_o;
  logic        rd_o;
  logic        rdy_i;
  logic [7:0]  in_i;
  logic        flush_i;
  logic [15:0] new_cs_i;
  logic [15:0] new_ip_i;
  logic        op_valid_o;
  logic        op_ready_i;
  logic [7:0]  opcode_o;
  logic [15:0] op_ips_o;
  logic [1:0]  op_seg_o;
  logic        op_over_o;
  logic [1:0]  op_rep_o;
  logic        op_lock_o;
  logic        op_ext_o;
  logic        op_fault_o;
  logic        byte_valid_o;
  logic [7:0]  byte_data_o;
  logic        byte_take_i;

  x86_prefetch_decoder #(
    .QDEPTH(6), .MAX_PREFIX(14), .RESET_CS(16'hF000), .RESET_IP(16'hFFF0)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .ce_i(ce_i),
    .address_o(address_o), .rd_o(rd_o), .rdy_i(rdy_i), .in_i(in_i),
    .flush_i(flush_i), .new_cs_i(new_cs_i), .new_ip_i(new_ip_i),
    .op_valid_o(op_valid_o), .op_ready_i(op_ready_i), .opcode_o(opcode_o),
    .op_ips_o(op_ips_o), .op_seg_o(op_seg_o), .op_over_o(op_over_o),
    .op_rep_o(op_rep_o), .op_lock_o(op_lock_o), .op_ext_o(op_ext_o),
    .op_fault_o(op_fault_o), .byte_valid_o(byte_valid_o),
    .byte_data_o(byte_data_o), .byte_take_i(byte_take_i)
  );

  always #5 clock_i = ~clock_i;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  mem [logic [19:0]];
  logic [31:0] sb [$];
  int          bus_lat  = 0;
  logic        bus_busy = 1'b0;
  logic [19:0] bus_addr;
  int          bus_dly;

  function automatic logic [31:0] mk_rec(input logic [7:0] opc, input logic [15:0] ips,
                                         input logic [1:0] seg, input logic over,
                                         input logic [1:0] rep, input logic lock,
                                         input logic ext, input logic fault);
    return {opc, ips, seg, over, rep, lock, ext, fault};
  endfunction

  function automatic logic [31:0] dut_rec();
    return {opcode_o, op_ips_o, op_seg_o, op_over_o, op_rep_o, op_lock_o, op_ext_o, op_fault_o};
  endfunction

  function automatic logic [7:0] mem_rd(input logic [19:0] a);
    return mem.exists(a) ? mem[a] : 8'h90;
  endfunction

  function automatic logic [19:0] lin(input logic [15:0] cs, input logic [15:0] ip);
    return {cs, 4'h0} + {4'h0, ip};
  endfunction

  // Bus model: accepts a read when rd is seen, answers after bus_lat idle cycles.
  initial begin
    rdy_i = 1'b0;
    in_i  = 8'h00;
    forever begin
      @(negedge clock_i);
      #1;
      rdy_i = 1'b0;
      if (bus_busy) begin
        if (bus_dly == 0) begin
          rdy_i    = 1'b1;
          in_i     = mem_rd(bus_addr);
          bus_busy = 1'b0;
        end else begin
          bus_dly--;
        end
      end else if (rd_o === 1'b1 && ce_i && !reset_i) begin
        bus_busy = 1'b1;
        bus_addr = address_o;
        bus_dly  = bus_lat;
      end
    end
  end

  // Monitor: every accepted record is compared against the scoreboard head.
  initial begin
    logic [31:0] exp_rec;
    forever begin
      @(negedge clock_i);
      #1;
      if (ce_i && !reset_i && !flush_i && op_valid_o && op_ready_i) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL record: unexpected record %h, scoreboard empty", dut_rec());
        end else begin
          exp_rec = sb.pop_front();
          if (dut_rec() !== exp_rec) begin
            miscompares++;
            $display("FAIL record: got %h expected %h", dut_rec(), exp_rec);
          end
        end
      end
    end
  end

  task automatic do_flush(input logic [15:0] cs, input logic [15:0] ip);
    @(negedge clock_i);
    flush_i  = 1'b1;
    new_cs_i = cs;
    new_ip_i = ip;
    @(negedge clock_i);
    flush_i = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input string name);
    int n = 0;
    @(negedge clock_i);
    op_ready_i = 1'b1;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clock_i);
      n++;
    end
    op_ready_i = 1'b0;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s drain: %0d records still expected after %0d cycles", name, sb.size(), n);
    end
  endtask

  task automatic wait_sig(input string name, input int which, output logic ok);
    int n = 0;
    ok = 1'b0;
    while (n < 60) begin
      @(negedge clock_i);
      #2;
      if ((which == 0 && op_valid_o) || (which == 1 && byte_valid_o) ||
          (which == 2 && rd_o) || (which == 3 && rdy_i) || (which == 4 && bus_busy)) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout waiting, got 0 required 1", name);
    end
  endtask

  task automatic test_reset();
    logic ok;
    reset_i = 1'b1; ce_i = 1'b1; flush_i = 1'b0; new_cs_i = '0; new_ip_i = '0;
    op_ready_i = 1'b0; byte_take_i = 1'b0; bus_lat = 0;
    mem[20'hFFFF0] = 8'hEA;
    repeat (3) @(negedge clock_i);
    reset_i = 1'b0;
    #2;
    vectors++;
    if ({address_o, rd_o, op_valid_o, byte_valid_o, op_seg_o, op_fault_o} !== {20'hFFFF0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: addr %h rd %b valid %b bvalid %b seg %0d fault %b, required FFFF0 1 0 0 3 0",
               address_o, rd_o, op_valid_o, byte_valid_o, op_seg_o, op_fault_o);
    end
    wait_sig("reset_first_rdy", 3, ok);
    if (!ok) return;
    vectors++;
    if (op_valid_o !== 1'b0) begin miscompares++; $display("FAIL latency_n0: op_valid %b required 0", op_valid_o); end
    @(negedge clock_i); #2;
    vectors++;
    if (op_valid_o !== 1'b0) begin miscompares++; $display("FAIL latency_n1: op_valid %b required 0", op_valid_o); end
    @(negedge clock_i); #2;
    vectors++;
    if (op_valid_o !== 1'b1) begin miscompares++; $display("FAIL latency_n2: op_valid %b required 1", op_valid_o); end
    vectors++;
    if (dut_rec() !== mk_rec(8'hEA, 16'hFFF0, 2'd3, 0, 2'd0, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL reset_record: got %h expected %h", dut_rec(), mk_rec(8'hEA, 16'hFFF0, 2'd3, 0, 2'd0, 0, 0, 0));
    end
  endtask

  task automatic test_prefix_merge();
    logic [7:0] prog [9] = '{8'h26, 8'hF3, 8'hF0, 8'h0F, 8'hA5, 8'h3E, 8'hF2, 8'h89, 8'h90};
    bus_lat = 1;
    for (int i = 0; i < 9; i++) mem[lin(16'h2000, 16'h0100 + 16'(i))] = prog[i];
    do_flush(16'h2000, 16'h0100);
    sb.push_back(mk_rec(8'hA5, 16'h0100, 2'd0, 1, 2'b11, 1, 1, 0));
    sb.push_back(mk_rec(8'h89, 16'h0105, 2'd3, 1, 2'b10, 0, 0, 0));
    sb.push_back(mk_rec(8'h90, 16'h0108, 2'd3, 0, 2'b00, 0, 0, 0));
    drain("prefix_merge");
  endtask

  task automatic test_prefix_limit();
    bus_lat = 0;
    for (int i = 0; i < 15; i++) mem[lin(16'h3000, 16'(i))] = 8'h2E;
    mem[lin(16'h3000, 16'h000F)] = 8'h90;
    for (int i = 0; i < 14; i++) mem[lin(16'h3000, 16'h0010 + 16'(i))] = 8'h26;
    mem[lin(16'h3000, 16'h001E)] = 8'h90;
    do_flush(16'h3000, 16'h0000);
    sb.push_back(mk_rec(8'h2E, 16'h0000, 2'd1, 1, 2'b00, 0, 0, 1));
    sb.push_back(mk_rec(8'h90, 16'h000F, 2'd3, 0, 2'b00, 0, 0, 0));
    sb.push_back(mk_rec(8'h90, 16'h0010, 2'd0, 1, 2'b00, 0, 0, 0));
    drain("prefix_limit");
  endtask

  task automatic test_back_to_back();
    logic [15:0] ip = 16'h0000;
    bus_lat = 0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 1) begin
        mem[lin(16'h4000, ip)] = 8'h36;
        sb.push_back(mk_rec(8'h80 + 8'(i), ip, 2'd2, 1, 2'b00, 0, 0, 0));
        ip++;
      end else begin
        sb.push_back(mk_rec(8'h80 + 8'(i), ip, 2'd3, 0, 2'b00, 0, 0, 0));
      end
      mem[lin(16'h4000, ip)] = 8'h80 + 8'(i);
      ip++;
    end
    begin
      logic [31:0] keep [$] = sb;
      do_flush(16'h4000, 16'h0000);
      sb = keep;
    end
    repeat (20) @(negedge clock_i);
    #2;
    vectors++;
    if ({rd_o, op_valid_o, address_o} !== {1'b0, 1'b1, 20'h40007}) begin
      miscompares++;
      $display("FAIL backpressure: rd %b valid %b addr %h, required 0 1 40007", rd_o, op_valid_o, address_o);
    end
    // Clock enable low: the record must not be consumed even with ready high.
    @(negedge clock_i);
    ce_i = 1'b0;
    op_ready_i = 1'b1;
    repeat (3) @(negedge clock_i);
    #2;
    vectors++;
    if ({op_valid_o, opcode_o, address_o} !== {1'b1, 8'h80, 20'h40007}) begin
      miscompares++;
      $display("FAIL ce_freeze: valid %b opcode %h addr %h, required 1 80 40007", op_valid_o, opcode_o, address_o);
    end
    @(negedge clock_i);
    op_ready_i = 1'b0;
    ce_i = 1'b1;
    drain("back_to_back");
  endtask

  task automatic test_flush_outstanding();
    logic ok;
    bus_lat = 4;
    mem[20'h50000] = 8'hCC;
    mem[20'h12350] = 8'hC3;
    do_flush(16'h5000, 16'h0000);
    wait_sig("flush_busy", 4, ok);
    if (!ok) return;
    do_flush(16'h1234, 16'h0010);
    #2;
    vectors++;
    if (rd_o !== 1'b0) begin miscompares++; $display("FAIL stale_block: rd %b required 0", rd_o); end
    wait_sig("flush_rd", 2, ok);
    if (!ok) return;
    vectors++;
    if (address_o !== 20'h12350) begin miscompares++; $display("FAIL flush_addr: got %h required 12350", address_o); end
    sb.push_back(mk_rec(8'hC3, 16'h0010, 2'd3, 0, 2'b00, 0, 0, 0));
    drain("flush");
  endtask

  task automatic test_byte_take();
    logic ok;
    logic [7:0] trail [2] = '{8'h11, 8'h22};
    bus_lat = 6;
    mem[20'h60000] = 8'h8B;
    mem[20'h60001] = 8'h11;
    mem[20'h60002] = 8'h22;
    mem[20'h60003] = 8'h90;
    do_flush(16'h6000, 16'h0000);
    sb.push_back(mk_rec(8'h8B, 16'h0000, 2'd3, 0, 2'b00, 0, 0, 0));
    sb.push_back(mk_rec(8'h90, 16'h0003, 2'd3, 0, 2'b00, 0, 0, 0));
    wait_sig("take_valid", 0, ok);
    if (!ok) return;
    vectors++;
    if (byte_valid_o !== 1'b0) begin miscompares++; $display("FAIL take_empty_valid: got %b required 0", byte_valid_o); end
    @(negedge clock_i);
    byte_take_i = 1'b1;
    @(negedge clock_i);
    byte_take_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_sig("take_byte", 1, ok);
      if (!ok) return;
      vectors++;
      if (byte_data_o !== trail[k]) begin
        miscompares++;
        $display("FAIL take_data%0d: got %h required %h", k, byte_data_o, trail[k]);
      end
      @(negedge clock_i);
      byte_take_i = 1'b1;
      @(negedge clock_i);
      byte_take_i = 1'b0;
    end
    #2;
    vectors++;
    if ({op_valid_o, opcode_o} !== {1'b1, 8'h8B}) begin
      miscompares++;
      $display("FAIL take_hold: valid %b opcode %h, required 1 8b", op_valid_o, opcode_o);
    end
    drain("byte_take");
  endtask

  initial begin
    test_reset();
    test_prefix_merge();
    test_prefix_limit();
    test_back_to_back();
    test_flush_outstanding();
    test_byte_take();
    repeat (3) @(negedge clock_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
